ps2_rx_events: RTL
==================

PS2_RX_EVENTS -- requirements
Module: ps2_rx_events

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered ps2k_clk changes level.
REQ-002 Parameter TIMEOUT_CYC, default 5000: clk cycles without a sample strobe, while mid-frame, before the frame is aborted.
REQ-003 Parameter FIFO_DEPTH, default 4, power of 2, >=2: event FIFO depth.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ps2k_clk  input  1  PS/2 clock, asynchronous.
REQ-007 ps2k_data  input  1  PS/2 data, asynchronous.
REQ-008 ev_valid  output  1  FIFO non-empty; head event presented.
REQ-009 ev_ready  input  1  consumer accepts the head event.
REQ-010 ev_code  output  8  head event scan code.
REQ-011 ev_ext  output  1  head event was preceded by 0xE0.
REQ-012 ev_brk  output  1  head event was preceded by 0xF0 (key release).
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of events stored.
REQ-014 parity_err  output  1  one-cycle pulse: byte failed odd parity.
REQ-015 frame_err  output  1  one-cycle pulse: bad start, bad stop or timeout.
REQ-016 overflow  output  1  one-cycle pulse: event dropped, FIFO full.
REQ-017 busy  output  1  receiver FSM not in IDLE.

Function
REQ-018 Both PS/2 inputs SHALL pass a 2-flop synchronizer; the synchronizer flops reset to 1.
REQ-019 Filtered clock SHALL take the synchronized level only after FILTER_LEN consecutive identical samples; it resets to 1.
REQ-020 Sample strobe SHALL be one cycle on each 1->0 transition of the filtered clock; synchronized ps2k_data is sampled on that cycle.
REQ-021 FSM states IDLE, DATA, PARITY, STOP; transitions occur only on strobe or timeout.
REQ-022 IDLE: strobe with data=0 -> DATA with bit count 0; strobe with data=1 -> remain IDLE and pulse frame_err.
REQ-023 DATA: 8 bits shifted LSB first; after the 8th bit -> PARITY.
REQ-024 PARITY: store the parity flag = (XOR of 8 data bits and parity bit == 1) -> STOP.
REQ-025 STOP: data=1 with parity OK -> byte delivered to the decoder; data=1 with parity bad -> parity_err pulse; data=0 -> frame_err pulse with byte discarded (frame_err takes precedence); in every case -> IDLE.
REQ-026 Timeout: while not IDLE, a counter increments each cycle and clears on strobe; reaching TIMEOUT_CYC -> IDLE, frame_err pulse, partial byte discarded.
REQ-027 Decoder: byte 0xE0 sets the ext flag; byte 0xF0 sets the brk flag; neither pushes an event.
REQ-028 Decoder: any other byte pushes {ext, brk, code} and clears both flags on the same cycle.
REQ-029 parity_err or frame_err SHALL clear the ext and brk flags.
REQ-030 FIFO is first-word fall-through: ev_* reflect the head whenever ev_valid=1; pop when ev_valid and ev_ready.
REQ-031 Push when full without a same-cycle pop: event dropped, FIFO unchanged, overflow pulse.
REQ-032 Push when full with a same-cycle pop: both performed, level unchanged, no overflow.
REQ-033 Push when empty: ev_valid high the following cycle; push-to-ev_valid latency 1 cycle.
REQ-034 ev_ready while empty has no effect; pointers wrap modulo FIFO_DEPTH.
REQ-035 fifo_level SHALL equal pushes minus pops accepted since reset, range 0..FIFO_DEPTH.

Reset
REQ-036 rst=1 at a clk edge: FSM IDLE, counters 0, ext/brk flags 0, FIFO empty, filter and synchronizers at 1.
REQ-037 Output values during and after reset: ev_valid 0, ev_code 0, ev_ext 0, ev_brk 0, fifo_level 0, all pulse outputs 0, busy 0.
REQ-038 Reset mid-frame SHALL discard the partial frame with no error pulse.

Verification
REQ-039 Valid frame 0x1C, ev_ready=1 -> exactly one event: code 0x1C, ext 0, brk 0; no error pulses.
REQ-040 Frames E0, F0, 75 -> exactly one event: code 0x75, ext 1, brk 1; fifo_level peaks at 1.
REQ-041 Frame 0x1C with inverted parity, then a valid 0x1B -> one parity_err pulse, then a single event with code 0x1B.
REQ-042 Frame halted after 5 data bits, idle >TIMEOUT_CYC -> one frame_err pulse and busy 0; the next valid frame decodes correctly.
REQ-043 ev_ready=0, send FIFO_DEPTH+1 keys -> fifo_level=FIFO_DEPTH and one overflow pulse; draining returns the first FIFO_DEPTH codes in order.
REQ-044 ps2k_clk low glitch of FILTER_LEN-1 cycles in IDLE -> no strobe, busy stays 0, no events.

Source files
------------

// File: rtl/ps2_rx_events.sv
// PS/2 keyboard receiver: deglitches the PS/2 clock, deframes odd-parity bytes
// and folds E0/F0 prefixes into key events held in a first-word-fall-through FIFO.
module ps2_rx_events #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2k_clk,
  input  logic                          ps2k_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          ext_flag, brk_flag;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count;
  logic          is_prefix, push, pop, full, do_push;

  // The strobe fires on the cycle the filtered clock commits to a new low level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      clk_s1 <= ps2k_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2k_data;
      dat_s2 <= dat_s1;
      strobe <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        strobe   <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      rx_valid   <= 1'b0;
      rx_byte    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state != S_IDLE && !strobe && to_cnt == TO_LAST) begin
        state     <= S_IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        if (state == S_IDLE || strobe) to_cnt <= '0;
        else                           to_cnt <= to_cnt + TW'(1);
        if (strobe) begin
          case (state)
            S_IDLE: begin
              if (!dat_s2) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
              end
            end
            S_DATA: begin
              shreg   <= {dat_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= S_PARITY;
            end
            S_PARITY: begin
              par_ok <= ^{shreg, dat_s2};
              state  <= S_STOP;
            end
            default: begin
              if (!dat_s2) begin
                frame_err <= 1'b1;
              end else if (par_ok) begin
                rx_valid <= 1'b1;
                rx_byte  <= shreg;
              end else begin
                parity_err <= 1'b1;
              end
              state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // Prefix flags accumulate until a real key byte consumes them or an error wipes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign is_prefix  = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
  assign push       = rx_valid && !is_prefix;
  assign pop        = ev_valid && ev_ready;
  assign full       = (count == LVL_FULL);
  assign do_push    = push && (!full || pop);
  assign ev_valid   = (count != '0);
  assign fifo_level = count;
  assign busy       = (state != S_IDLE);
  assign {ev_ext, ev_brk, ev_code} = ev_valid ? mem[rptr] : 10'd0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {ext_flag, brk_flag, rx_byte};
  end

  // A push into a full FIFO succeeds only when the head leaves on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
